// File: rtl/rr_arbiter4.sv
// Four-input round-robin arbiter feeding a one-entry registered output stage.
// Define RR_ARBITER4_LOCK_EN to hold the grant on one channel until its io_in_last beat.
module rr_arbiter4 #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid_0,
   input  logic             io_in_valid_1,
   input  logic             io_in_valid_2,
   input  logic             io_in_valid_3,
   input  logic [WIDTH-1:0] io_in_data_0,
   input  logic [WIDTH-1:0] io_in_data_1,
   input  logic [WIDTH-1:0] io_in_data_2,
   input  logic [WIDTH-1:0] io_in_data_3,
`ifdef RR_ARBITER4_LOCK_EN
   input  logic             io_in_last_0,
   input  logic             io_in_last_1,
   input  logic             io_in_last_2,
   input  logic             io_in_last_3,
`endif
   output logic             io_in_ready_0,
   output logic             io_in_ready_1,
   output logic             io_in_ready_2,
   output logic             io_in_ready_3,
   output logic [1:0]       io_select,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out_data,
   output logic [1:0]       io_out_chosen,
   output logic [1:0]       dbg_ptr,
   output logic             dbg_lock
);

   // Handshake: a beat moves on any rising edge where valid and ready are both 1.
   // Ready never depends on the valid of the same interface's consumer side beyond
   // the grant search, and a presented output beat stays stable until it is taken.

   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [1:0]       out_chosen_q;
   logic [1:0]       ptr_q;

   logic [3:0]       valid_vec;
   logic [WIDTH-1:0] data_arr [4];
   logic             accept_en;
   logic             accept;
   logic [1:0]       grant;
   logic             grant_found;

   assign valid_vec   = {io_in_valid_3, io_in_valid_2, io_in_valid_1, io_in_valid_0};
   assign data_arr[0] = io_in_data_0;
   assign data_arr[1] = io_in_data_1;
   assign data_arr[2] = io_in_data_2;
   assign data_arr[3] = io_in_data_3;

`ifdef RR_ARBITER4_LOCK_EN
   typedef enum logic {ARB_FREE, ARB_LOCKED} lock_state_t;
   lock_state_t lock_state_q;
   logic [1:0]  lock_idx_q;
   logic [3:0]  last_vec;

   assign last_vec = {io_in_last_3, io_in_last_2, io_in_last_1, io_in_last_0};
   assign dbg_lock = (lock_state_q == ARB_LOCKED);
`else
   assign dbg_lock = 1'b0;
`endif

   // Scan from the farthest candidate back to ptr so the nearest valid one wins.
   always_comb begin
      logic [1:0] idx;
      idx         = '0;
      grant       = '0;
      grant_found = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr_q + 2'(k);
         if (valid_vec[idx]) begin
            grant       = idx;
            grant_found = 1'b1;
         end
      end
`ifdef RR_ARBITER4_LOCK_EN
      if (lock_state_q == ARB_LOCKED) begin
         grant       = lock_idx_q;
         grant_found = valid_vec[lock_idx_q];
      end
`endif
   end

   assign accept_en = !out_valid_q || io_out_ready;
   assign accept    = grant_found && accept_en && !reset;

   assign io_select     = grant;
   assign io_in_ready_0 = accept && (grant == 2'd0);
   assign io_in_ready_1 = accept && (grant == 2'd1);
   assign io_in_ready_2 = accept && (grant == 2'd2);
   assign io_in_ready_3 = accept && (grant == 2'd3);

   assign io_out_valid  = out_valid_q;
   assign io_out_data   = out_data_q;
   assign io_out_chosen = out_chosen_q;
   assign dbg_ptr       = ptr_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_chosen_q <= '0;
         ptr_q        <= '0;
`ifdef RR_ARBITER4_LOCK_EN
         lock_state_q <= ARB_FREE;
         lock_idx_q   <= '0;
`endif
      end else begin
         if (accept) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= data_arr[grant];
            out_chosen_q <= grant;
`ifdef RR_ARBITER4_LOCK_EN
            if (last_vec[grant]) begin
               ptr_q        <= grant + 2'd1;
               lock_state_q <= ARB_FREE;
            end else begin
               lock_state_q <= ARB_LOCKED;
               lock_idx_q   <= grant;
            end
`else
            ptr_q        <= grant + 2'd1;
`endif
         end else if (io_out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed scoreboard bench for rr_arbiter4: driver pushes expected {chosen,data},
// a negedge monitor pops and compares on every output transfer.
module tb_rr_arbiter4;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   in_valid = '0;
   logic [W-1:0] in_data [4];
   logic [3:0]   in_last = '0;
   logic [3:0]   in_ready;
   logic [1:0]   io_select;
   logic         io_out_valid;
   logic         io_out_ready = 1'b1;
   logic [W-1:0] io_out_data;
   logic [1:0]   io_out_chosen;
   logic [1:0]   dbg_ptr;
   logic         dbg_lock;

   int tests_run = 0;
   int tests_failed = 0;
   logic [W+1:0] exp_q[$];

   rr_arbiter4 #(.WIDTH(W)) dut (
      .clock         (clock),
      .reset         (reset),
      .io_in_valid_0 (in_valid[0]),
      .io_in_valid_1 (in_valid[1]),
      .io_in_valid_2 (in_valid[2]),
      .io_in_valid_3 (in_valid[3]),
      .io_in_data_0  (in_data[0]),
      .io_in_data_1  (in_data[1]),
      .io_in_data_2  (in_data[2]),
      .io_in_data_3  (in_data[3]),
`ifdef RR_ARBITER4_LOCK_EN
      .io_in_last_0  (in_last[0]),
      .io_in_last_1  (in_last[1]),
      .io_in_last_2  (in_last[2]),
      .io_in_last_3  (in_last[3]),
`endif
      .io_in_ready_0 (in_ready[0]),
      .io_in_ready_1 (in_ready[1]),
      .io_in_ready_2 (in_ready[2]),
      .io_in_ready_3 (in_ready[3]),
      .io_select     (io_select),
      .io_out_valid  (io_out_valid),
      .io_out_ready  (io_out_ready),
      .io_out_data   (io_out_data),
      .io_out_chosen (io_out_chosen),
      .dbg_ptr       (dbg_ptr),
      .dbg_lock      (dbg_lock)
   );

   // clock/reset
   always #5 clock = ~clock;

   task automatic check(input string name, input int actual, input int expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [1:0] chosen, input logic [W-1:0] data);
      exp_q.push_back({chosen, data});
   endtask

   // scoreboard monitor
   always @(negedge clock) begin
      if (!reset && io_out_valid && io_out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", {io_out_chosen, io_out_data}, -1);
         end else begin
            logic [W+1:0] e;
            e = exp_q.pop_front();
            check("out_chosen", io_out_chosen, e[W+1:W]);
            check("out_data", io_out_data, e[W-1:0]);
         end
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) in_data[i] = '0;

      // Round robin with all four requesters busy; ready must stay low in reset.
      in_valid = 4'hF;
      in_data[0] = 8'h10; in_data[1] = 8'h11; in_data[2] = 8'h12; in_data[3] = 8'h13;
      #2;
      check("reset_out_valid", io_out_valid, 0);
      check("reset_out_data", io_out_data, 0);
      check("reset_ptr", dbg_ptr, 0);
      check("reset_ready", in_ready, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      push(2'd0, 8'h10); push(2'd1, 8'h11); push(2'd2, 8'h12);
      push(2'd3, 8'h13); push(2'd0, 8'h10);
      @(negedge clock);
      check("rr_first_select", io_select, 0);
      check("rr_first_ready", in_ready, 4'b0001);
      for (int i = 0; i < 5; i++) step();
      in_valid = '0;

      // Single requester on channel 2.
      in_valid[2] = 1'b1; in_data[2] = 8'hA5;
      push(2'd2, 8'hA5);
      @(negedge clock);
      check("single_select", io_select, 2);
      check("single_ready", in_ready, 4'b0100);
      step();
      in_valid = '0;
      check("single_out_valid", io_out_valid, 1);
      check("single_ptr", dbg_ptr, 3);
      step(); step();
      check("idle_ptr_hold", dbg_ptr, 3);
      check("idle_out_empty", io_out_valid, 0);

      // Back-pressure: output full, consumer stalls three cycles.
      io_out_ready = 1'b0;
      in_valid[0] = 1'b1; in_data[0] = 8'h20;
      push(2'd0, 8'h20);
      step();
      in_valid = '0;
      in_valid[1] = 1'b1; in_data[1] = 8'h31;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("stall_ready", in_ready, 0);
         check("stall_hold_data", io_out_data, 8'h20);
         check("stall_hold_valid", io_out_valid, 1);
         step();
      end
      io_out_ready = 1'b1;
      @(negedge clock);
      check("unstall_ready", in_ready, 4'b0010);
      step();
      io_out_ready = 1'b0;
      in_valid = '0;
      check("unstall_load_data", io_out_data, 8'h31);
      check("unstall_load_chosen", io_out_chosen, 1);
      check("unstall_ptr", dbg_ptr, 2);

      // Asynchronous reset while a beat is held and ptr = 2.
      #2;
      reset = 1'b1;
      in_valid[3] = 1'b1; in_data[3] = 8'h43;
      in_valid[0] = 1'b1; in_data[0] = 8'h40;
      #1;
      check("async_out_valid", io_out_valid, 0);
      check("async_ptr", dbg_ptr, 0);
      check("async_ready", in_ready, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      io_out_ready = 1'b1;
      push(2'd0, 8'h40);
      @(negedge clock);
      check("post_reset_select", io_select, 0);
      check("post_reset_ready", in_ready, 4'b0001);
      step();
      in_valid[0] = 1'b0;
      push(2'd3, 8'h43);
      @(negedge clock);
      check("post_reset_second", io_select, 3);
      step();
      in_valid = '0;

`ifdef RR_ARBITER4_LOCK_EN
      // Packet lock on channel 1 with channel 2 competing, ptr = 0 here.
      in_valid[1] = 1'b1; in_data[1] = 8'h51; in_last[1] = 1'b0;
      in_valid[2] = 1'b1; in_data[2] = 8'h62; in_last[2] = 1'b1;
      push(2'd1, 8'h51);
      step();
      check("lock_set", dbg_lock, 1);
      in_valid[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         check("lock_idle_ready", in_ready, 0);
         check("lock_idle_select", io_select, 1);
         step();
      end
      in_valid[1] = 1'b1; in_data[1] = 8'h52;
      push(2'd1, 8'h52);
      step();
      check("lock_ptr_hold", dbg_ptr, 0);
      in_data[1] = 8'h53; in_last[1] = 1'b1;
      push(2'd1, 8'h53);
      step();
      check("lock_clear", dbg_lock, 0);
      check("lock_ptr_adv", dbg_ptr, 2);
      in_valid[1] = 1'b0; in_last[1] = 1'b0;
      push(2'd2, 8'h62);
      step();
      in_valid = '0;
`endif

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
      @(negedge clock);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
